// File: rtl/toggle_pkg.sv
// -----------------------------------------------------------------------------
// toggle_pkg
// Shared definitions for the toggle-signalling receive path.
//   state_t      : FSM encoding reported on the debug state output
//   DEF_CNT_W    : default interval counter width
//   DEF_TIMEOUT  : default inactivity limit in clk cycles
// -----------------------------------------------------------------------------
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // no edge seen since reset
        ARMED  = 2'd1,   // one edge seen, interval not yet known
        LOCKED = 2'd2,   // period holds a measured interval
        STALL  = 2'd3    // no activity for TIMEOUT cycles
    } state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1000;

endpackage

// File: rtl/toggle_rx_if.sv
// -----------------------------------------------------------------------------
// toggle_rx_if
// Bundle between a toggle producer/consumer and toggle_rx.
//   t_in        : asynchronous toggle line into the receiver
//   pulse       : one-cycle strobe per accepted toggle
//   rise/fall   : one-cycle strobes qualified by direction
//   period      : cycles between the last two accepted toggles (saturating)
//   period_vld  : one-cycle strobe when period loads
//   period_ovf  : latest period load saturated
//   timeout     : level, no toggle for TIMEOUT cycles
//   state       : receiver FSM state (debug)
// Modports: master = receiver side (toggle_rx), slave = producer/consumer side.
// -----------------------------------------------------------------------------
interface toggle_rx_if #(
    parameter int CNT_W = toggle_pkg::DEF_CNT_W
);
    logic             t_in;
    logic             pulse;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             period_ovf;
    logic             timeout;
    logic [1:0]       state;

    modport master (
        input  t_in,
        output pulse, rise, fall, period, period_vld, period_ovf, timeout, state
    );

    modport slave (
        output t_in,
        input  pulse, rise, fall, period, period_vld, period_ovf, timeout, state
    );
endinterface

// File: rtl/toggle_sync.sv
// -----------------------------------------------------------------------------
// toggle_sync
// Plain multi-flop synchroniser for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input level
//   q   : synchronised level, SYNC_STAGES clk edges after d is first sampled
// -----------------------------------------------------------------------------
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_p;

    // Stage boundary: sync_p[0] is the metastable capture flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// -----------------------------------------------------------------------------
// toggle_rx
// Receive end of a toggle-encoded event line. Resynchronises t_in into clk,
// converts each level change into one-cycle strobes, measures the interval
// between consecutive toggles and flags loss of activity.
//   clk : single clock, all state on its rising edge
//   rst : asynchronous active-high reset
//   bus : toggle_rx_if.master (t_in in; pulse, rise, fall, period,
//         period_vld, period_ovf, timeout, state out; all outputs registered)
// Build option: define TOGGLE_RX_GLITCH_FILTER_EN to require a changed level
// to persist for 2 cycles before it is accepted (one extra cycle of latency).
// -----------------------------------------------------------------------------
module toggle_rx
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    toggle_rx_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

    // Saturating increment: the interval counter parks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic             t_sync;
    logic             t_q;
    logic             diff;
    logic             edge_det;
    logic [CNT_W-1:0] cnt;
    state_t           state_q;
    state_t           state_d;
    logic             load;

    logic             pulse_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] period_q;
    logic             period_vld_q;
    logic             period_ovf_q;
    logic             timeout_q;

    toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.t_in),
        .q   (t_sync)
    );

    assign diff = (t_sync != t_q);

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
    // pend remembers that the level already differed last cycle; a second
    // consecutive mismatch is accepted, a one-cycle mismatch is dropped.
    logic pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= diff && !edge_det;
        end
    end

    assign edge_det = diff && pend;
`else
    assign edge_det = diff;
`endif

    // Stage boundary: t_q only follows the synchronised level on acceptance,
    // so a rejected glitch leaves the reference level untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q <= 1'b0;
        end else if (edge_det) begin
            t_q <= t_sync;
        end
    end

    // Next-state logic. An edge always wins over the timeout check, so an
    // edge in the cycle cnt reaches TIMEOUT is measured and never stalls.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (edge_det) state_d = ARMED;
            end
            ARMED: begin
                if (edge_det) begin
                    state_d = LOCKED;
                    load    = 1'b1;
                end else if (cnt == CNT_TO) begin
                    state_d = STALL;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    load = 1'b1;
                end else if (cnt == CNT_TO) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                // The interval that ended here is unbounded: no period load.
                if (edge_det) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage boundary: registered outputs, counter and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt          <= '0;
            pulse_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            period_ovf_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt          <= edge_det ? CNT_W'(1) : sat_inc(cnt);
            pulse_q      <= edge_det;
            rise_q       <= edge_det && t_sync;
            fall_q       <= edge_det && !t_sync;
            period_vld_q <= load;
            timeout_q    <= (state_d == STALL);
            if (load) begin
                period_q     <= cnt;
                period_ovf_q <= (cnt == CNT_MAX);
            end
        end
    end

    assign bus.pulse      = pulse_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;
    assign bus.period_ovf = period_ovf_q;
    assign bus.timeout    = timeout_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_toggle_rx.sv
// -----------------------------------------------------------------------------
// tb_toggle_rx
// Directed bench for toggle_rx. dut_a: SYNC_STAGES=2, CNT_W=16, TIMEOUT=16.
// dut_b: SYNC_STAGES=2, CNT_W=4, TIMEOUT=15 (saturation corner).
// PD is the number of clk edges from driving t_in (just after an edge) to
// the cycle in which pulse is observed: the first edge samples the level,
// SYNC_STAGES further edges produce the registered strobe.
// -----------------------------------------------------------------------------
module tb_toggle_rx;

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
    localparam int PD = 4;
`else
    localparam int PD = 3;
`endif

    logic clk;
    logic rst;

    toggle_rx_if #(.CNT_W(16)) ifa ();
    toggle_rx_if #(.CNT_W(4))  ifb ();

    toggle_rx #(.SYNC_STAGES(2), .CNT_W(16), .TIMEOUT(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    toggle_rx #(.SYNC_STAGES(2), .CNT_W(4), .TIMEOUT(15)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic t;       // level driven
        int   gap;     // cycles until the next record is driven
        logic rise;
        logic fall;
        logic vld;
        int   period;  // expected period at the pulse
        int   st;      // expected state at the pulse
    } vec_t;

    vec_t tbl [7];
    int   n_vec;
    int   n_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero_a(input string nm);
        chk({nm, ".pulse"},   int'(ifa.pulse),      0);
        chk({nm, ".rise"},    int'(ifa.rise),       0);
        chk({nm, ".fall"},    int'(ifa.fall),       0);
        chk({nm, ".vld"},     int'(ifa.period_vld), 0);
        chk({nm, ".period"},  int'(ifa.period),     0);
        chk({nm, ".ovf"},     int'(ifa.period_ovf), 0);
        chk({nm, ".timeout"}, int'(ifa.timeout),    0);
        chk({nm, ".state"},   int'(ifa.state),      0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //                t     gap rise  fall  vld   per st
        tbl[0] = '{1'b1, 4, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[1] = '{1'b0, 4, 1'b0, 1'b1, 1'b1, 4, 2};
        tbl[2] = '{1'b1, 4, 1'b1, 1'b0, 1'b1, 4, 2};
        tbl[3] = '{1'b0, 4, 1'b0, 1'b1, 1'b1, 4, 2};
        tbl[4] = '{1'b1, 7, 1'b1, 1'b0, 1'b1, 4, 2};
        tbl[5] = '{1'b0, 6, 1'b0, 1'b1, 1'b1, 7, 2};
        tbl[6] = '{1'b1, 5, 1'b1, 1'b0, 1'b1, 6, 2};

        // Reset values
        rst      = 1'b1;
        ifa.t_in = 1'b0;
        ifb.t_in = 1'b0;
        repeat (3) tick();
        chk_zero_a("rst_a");
        chk("rst_b.state", int'(ifb.state), 0);
        chk("rst_b.pulse", int'(ifb.pulse), 0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst.strobes", int'({ifa.pulse, ifa.rise, ifa.fall, ifa.period_vld}), 0);
            chk("post_rst.state", int'(ifa.state), 0);
        end

        // Steady toggling, table driven
        for (int i = 0; i < 7; i++) begin
            ifa.t_in = tbl[i].t;
            for (int c = 1; c <= tbl[i].gap; c++) begin
                tick();
                if (c == PD) begin
                    chk($sformatf("tbl%0d.pulse", i),  int'(ifa.pulse),      1);
                    chk($sformatf("tbl%0d.rise", i),   int'(ifa.rise),       int'(tbl[i].rise));
                    chk($sformatf("tbl%0d.fall", i),   int'(ifa.fall),       int'(tbl[i].fall));
                    chk($sformatf("tbl%0d.vld", i),    int'(ifa.period_vld), int'(tbl[i].vld));
                    chk($sformatf("tbl%0d.period", i), int'(ifa.period),     tbl[i].period);
                    chk($sformatf("tbl%0d.state", i),  int'(ifa.state),      tbl[i].st);
                end else begin
                    chk($sformatf("tbl%0d.nopulse", i), int'(ifa.pulse), 0);
                end
            end
        end

        // Last toggle before going quiet: interval 5 since the previous one
        ifa.t_in = 1'b0;
        repeat (PD) tick();
        chk("hold.pulse",  int'(ifa.pulse),      1);
        chk("hold.vld",    int'(ifa.period_vld), 1);
        chk("hold.period", int'(ifa.period),     5);

        // Timeout: cnt hits 16 in the 16th cycle counting the pulse cycle
        // as 1; timeout shows in the 17th.
        repeat (15) tick();
        chk("to_early.timeout", int'(ifa.timeout), 0);
        chk("to_early.state",   int'(ifa.state),   2);
        tick();
        chk("to.timeout", int'(ifa.timeout), 1);
        chk("to.state",   int'(ifa.state),   3);

        // Toggle out of STALL: no period load, back to ARMED
        ifa.t_in = 1'b1;
        repeat (PD) tick();
        chk("unstall.pulse",   int'(ifa.pulse),      1);
        chk("unstall.rise",    int'(ifa.rise),       1);
        chk("unstall.vld",     int'(ifa.period_vld), 0);
        chk("unstall.timeout", int'(ifa.timeout),    0);
        chk("unstall.state",   int'(ifa.state),      1);
        chk("unstall.period",  int'(ifa.period),     5);

        // Re-lock with a PD-cycle interval
        ifa.t_in = 1'b0;
        repeat (PD) tick();
        chk("relock.vld",    int'(ifa.period_vld), 1);
        chk("relock.period", int'(ifa.period),     PD);
        chk("relock.state",  int'(ifa.state),      2);

        // Reset mid-operation with t_in high
        ifa.t_in = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk_zero_a("midrst");
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 1; c <= PD; c++) begin
            tick();
            if (c < PD) begin
                chk("midrst.nopulse", int'(ifa.pulse), 0);
            end else begin
                chk("midrst.rise",  int'(ifa.rise),       1);
                chk("midrst.pulse", int'(ifa.pulse),      1);
                chk("midrst.vld",   int'(ifa.period_vld), 0);
                chk("midrst.state", int'(ifa.state),      1);
            end
        end

        // Saturation on the narrow counter
        ifb.t_in = 1'b1;
        repeat (PD) tick();
        chk("sat0.pulse", int'(ifb.pulse), 1);
        chk("sat0.state", int'(ifb.state), 1);
        repeat (12 - PD) tick();
        ifb.t_in = 1'b0;
        repeat (PD) tick();
        chk("sat12.vld",    int'(ifb.period_vld), 1);
        chk("sat12.period", int'(ifb.period),     12);
        chk("sat12.ovf",    int'(ifb.period_ovf), 0);
        chk("sat12.state",  int'(ifb.state),      2);
        repeat (15 - PD) tick();
        ifb.t_in = 1'b1;
        repeat (PD) tick();
        chk("sat15.vld",     int'(ifb.period_vld), 1);
        chk("sat15.period",  int'(ifb.period),     15);
        chk("sat15.ovf",     int'(ifb.period_ovf), 1);
        chk("sat15.state",   int'(ifb.state),      2);
        chk("sat15.timeout", int'(ifb.timeout),    0);

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
        // One-cycle glitch is rejected; a held change is accepted
        ifa.t_in = 1'b0;
        tick();
        ifa.t_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("glitch.nopulse", int'(ifa.pulse), 0);
        end
        ifa.t_in = 1'b0;
        repeat (PD) tick();
        chk("filt.pulse", int'(ifa.pulse), 1);
        chk("filt.fall",  int'(ifa.fall),  1);
        tick();
        chk("filt.single", int'(ifa.pulse), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
